// File: rtl/axis_video_frame_source_pkg.sv
// Shared definitions for the video frame source: FSM states,
// LFSR taps and default image-size widths.
package axis_video_frame_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_IMG_WBITS = 12;
    localparam int DEF_IMG_HBITS = 12;

    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting left
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_video_frame_source_if.sv
// AXI4-Stream video bundle: pixel data plus SOF (tuser) and EOL (tlast).
interface axis_video_frame_source_if #(
    parameter int C_PIXEL_WIDTH = 8
) ();

    logic                     tvalid;
    logic [C_PIXEL_WIDTH-1:0] tdata;
    logic                     tuser;
    logic                     tlast;
    logic                     tready;

    modport master (
        output tvalid, tdata, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tlast,
        output tready
    );

endinterface

// File: rtl/axis_video_frame_source_lfsr16.sv
// 16-bit maximal-length LFSR used to throttle beat issue.
module lfsr16
    import axis_video_frame_source_pkg::*;
#(
    parameter logic [15:0] C_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= C_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/axis_video_frame_source.sv
// Frame generator: one width x height pattern frame per accepted start,
// pixel = row*C_ROW_STRIDE + col, SOF on first beat, EOL on line end.
module axis_video_frame_source
    import axis_video_frame_source_pkg::*;
#(
    parameter int          C_PIXEL_WIDTH = 8,
    parameter int          C_IMG_WBITS   = DEF_IMG_WBITS,
    parameter int          C_IMG_HBITS   = DEF_IMG_HBITS,
    parameter int          C_ROW_STRIDE  = 10,
    parameter int          C_THROTTLE    = 0,
    parameter logic [15:0] C_LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [C_IMG_WBITS-1:0] width,
    input  logic [C_IMG_HBITS-1:0] height,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    axis_video_frame_source_if.master M_AXIS
);

    localparam logic [C_PIXEL_WIDTH-1:0] STRIDE =
        C_PIXEL_WIDTH'(C_ROW_STRIDE);

    state_t state, state_nx;

    logic [C_IMG_WBITS-1:0]   w_q;
    logic [C_IMG_HBITS-1:0]   h_q;
    logic [C_IMG_WBITS-1:0]   col_q;
    logic [C_IMG_HBITS-1:0]   row_q;
    logic [C_PIXEL_WIDTH-1:0] acc_q;
    logic                     pending_q;
    logic                     last_q;

    logic                     tvalid_q;
    logic [C_PIXEL_WIDTH-1:0] tdata_q;
    logic                     tuser_q;
    logic                     tlast_q;

    logic hs;
    logic start_ok;
    logic zero_dim;
    logic gate;
    logic can_issue;
    logic col_end;
    logic row_end;

    assign hs        = tvalid_q & M_AXIS.tready;
    assign start_ok  = start & (state == ST_IDLE);
    assign zero_dim  = (width == '0) | (height == '0);
    assign col_end   = (col_q == w_q - C_IMG_WBITS'(1));
    assign row_end   = (row_q == h_q - C_IMG_HBITS'(1));
    assign can_issue = (state == ST_RUN) & pending_q &
                       (~tvalid_q | hs) & gate;

    generate
        if (C_THROTTLE != 0) begin : g_thr
            logic [15:0] lfsr_q;

            lfsr16 #(
                .C_SEED (C_LFSR_SEED)
            ) u_lfsr (
                .clk    (clk),
                .resetn (resetn),
                .en     (state == ST_RUN),
                .q      (lfsr_q)
            );

            // a nonzero register never locks up; |lfsr_q is a guard
            assign gate = lfsr_q[0] & (|lfsr_q);
        end else begin : g_nothr
            assign gate = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = zero_dim ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs & last_q) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            acc_q     <= '0;
            pending_q <= 1'b0;
            last_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                w_q       <= width;
                h_q       <= height;
                col_q     <= '0;
                row_q     <= '0;
                acc_q     <= '0;
                pending_q <= ~zero_dim;
            end
            if (hs) begin
                tvalid_q <= 1'b0;
            end
            // counters track the next beat to present, not the one on the bus
            if (can_issue) begin
                tvalid_q <= 1'b1;
                tdata_q  <= acc_q + C_PIXEL_WIDTH'(col_q);
                tuser_q  <= (row_q == '0) & (col_q == '0);
                tlast_q  <= col_end;
                last_q   <= col_end & row_end;
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_q + C_IMG_HBITS'(1);
                    acc_q <= acc_q + STRIDE;
                    if (row_end) begin
                        pending_q <= 1'b0;
                    end
                end else begin
                    col_q <= col_q + C_IMG_WBITS'(1);
                end
            end
        end
    end

    assign M_AXIS.tvalid = tvalid_q;
    assign M_AXIS.tdata  = tdata_q;
    assign M_AXIS.tuser  = tuser_q;
    assign M_AXIS.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_video_frame_source.sv
// Directed bench: one unthrottled and one throttled source, checked
// beat by beat against the row*10+col pattern.
module tb_axis_video_frame_source;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] width = '0;
    logic [11:0] height = '0;
    logic        tready = 1'b1;
    logic        dsel = 1'b0;

    logic busy0, fd0, busy1, fd1;
    logic start0, start1;

    int n_cmp = 0;
    int n_err = 0;
    int gaps;

    axis_video_frame_source_if #(.C_PIXEL_WIDTH(8)) ax0 ();
    axis_video_frame_source_if #(.C_PIXEL_WIDTH(8)) ax1 ();

    assign ax0.tready = tready;
    assign ax1.tready = tready;
    assign start0 = start & ~dsel;
    assign start1 = start & dsel;

    always #5 clk = ~clk;

    axis_video_frame_source #(.C_THROTTLE(0)) u_dut0 (
        .clk        (clk),
        .resetn     (resetn),
        .width      (width),
        .height     (height),
        .start      (start0),
        .busy       (busy0),
        .frame_done (fd0),
        .M_AXIS     (ax0.master)
    );

    axis_video_frame_source #(.C_THROTTLE(1)) u_dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .width      (width),
        .height     (height),
        .start      (start1),
        .busy       (busy1),
        .frame_done (fd1),
        .M_AXIS     (ax1.master)
    );

    wire       v  = dsel ? ax1.tvalid : ax0.tvalid;
    wire [7:0] d  = dsel ? ax1.tdata  : ax0.tdata;
    wire       u  = dsel ? ax1.tuser  : ax0.tuser;
    wire       l  = dsel ? ax1.tlast  : ax0.tlast;
    wire       bz = dsel ? busy1 : busy0;
    wire       fd = dsel ? fd1   : fd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input string tag);
        width  = 12'(w);
        height = 12'(h);
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk({tag, " accept"}, {bz, v}, 2'b10);
    endtask

    task automatic run_frame(input int w, input int h, input bit rnd,
                             input int poke, input int abort_at,
                             input string tag, output int ngap);
        int       k = 0;
        bit       pv = 1'b0;
        bit       pr = 1'b0;
        bit       fin = 1'b0;
        bit       poked = 1'b0;
        logic [9:0] held = '0;
        logic [7:0] ed;
        ngap = 0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            start  = 1'b0;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pv && !pr) begin
                chk({tag, " hold"}, {v, d, u, l}, {1'b1, held});
            end
            if (!v) ngap++;
            if (v && k == abort_at) begin
                resetn = 1'b0;
                step();
                chk({tag, " abort"}, {v, bz, fd}, 3'b000);
                resetn = 1'b1;
                return;
            end
            if (v && k == poke && !poked) begin
                poked = 1'b1;
                start = 1'b1;
                width = 12'd5;
            end
            if (v && tready) begin
                ed = 8'(((k / w) * 10) + (k % w));
                chk({tag, " beat"}, {d, u, l},
                    {ed, k == 0, (k % w) == (w - 1)});
                if (k == w * h - 1) fin = 1'b1;
                k++;
            end
            pv   = v;
            pr   = tready;
            held = {d, u, l};
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        tready = 1'b1;
        chk({tag, " count"}, 32'(k), 32'(w * h));
        chk({tag, " done"}, {fd, bz, v}, 3'b110);
        step();
        chk({tag, " idle"}, {fd, bz, v}, 3'b000);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) step();
        chk("rst0", {ax0.tvalid, ax0.tdata, ax0.tuser, ax0.tlast, busy0, fd0}, 0);
        chk("rst1", {ax1.tvalid, ax1.tdata, ax1.tuser, ax1.tlast, busy1, fd1}, 0);
        resetn = 1'b1;
        step();

        // 10x10, continuous ready, first beat one cycle after accept
        dsel = 1'b0;
        start_frame(10, 10, "t1");
        step();
        chk("t1 first", {v, d, u}, {1'b1, 8'd0, 1'b1});
        run_frame(10, 10, 1'b0, -1, -1, "t1", gaps);
        chk("t1 nogap", 32'(gaps), 32'd0);

        // random backpressure
        start_frame(10, 10, "t2");
        run_frame(10, 10, 1'b1, -1, -1, "t2", gaps);

        // throttled source
        dsel = 1'b1;
        step();
        start_frame(10, 10, "t3");
        run_frame(10, 10, 1'b0, -1, -1, "t3", gaps);
        chk("t3 gaps", 32'(gaps > 1), 32'd1);

        // throttled with backpressure
        start_frame(7, 3, "t3b");
        run_frame(7, 3, 1'b1, -1, -1, "t3b", gaps);

        // single-column frame
        dsel = 1'b0;
        step();
        start_frame(1, 4, "t4");
        run_frame(1, 4, 1'b0, -1, -1, "t4", gaps);

        // empty frames
        start_frame(0, 3, "t4w0");
        chk("t4w0 pulse", {fd, bz, v}, 3'b110);
        step();
        chk("t4w0 end", {fd, bz, v}, 3'b000);
        start_frame(4, 0, "t4h0");
        chk("t4h0 pulse", {fd, bz, v}, 3'b110);
        step();
        chk("t4h0 end", {fd, bz, v}, 3'b000);

        // start and width change mid-frame are ignored
        start_frame(10, 10, "t5");
        run_frame(10, 10, 1'b0, 37, -1, "t5", gaps);
        step();
        chk("t5 noq", {bz, v}, 2'b00);

        // reset mid-frame, then fresh frame
        start_frame(10, 10, "t6");
        run_frame(10, 10, 1'b0, -1, 55, "t6", gaps);
        step();
        chk("t6 quiet", {bz, v, fd}, 3'b000);
        start_frame(10, 10, "t6b");
        run_frame(10, 10, 1'b1, -1, -1, "t6b", gaps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
